// File: rtl/train_sensor_conditioner.sv
// Track-sensor input conditioning: two-flop synchronizer, per-channel debounce,
// rising-edge event capture and a level/ack handshake toward the train controller.
module train_sensor_conditioner #(
    parameter int NUM_SENSORS     = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ID_W            = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1,
    parameter int CNT_W           = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SENSORS-1:0] sensor_raw,
    input  logic                   ack,
    input  logic                   clear_overrun,
    output logic                   y,
    output logic [ID_W-1:0]        sensor_id,
    output logic [NUM_SENSORS-1:0] sensor_level,
    output logic                   overrun
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SENSORS-1:0] s1_r;
    logic [NUM_SENSORS-1:0] s2_r;
    logic [NUM_SENSORS-1:0] stable_r;
    logic [NUM_SENSORS-1:0] pending_r;
    logic [CNT_W-1:0]       cnt_r [NUM_SENSORS];
    logic                   overrun_r;

    logic [NUM_SENSORS-1:0] rise_s;
    logic [NUM_SENSORS-1:0] ack_hit_s;
    logic                   y_s;
    logic [ID_W-1:0]        id_s;
    logic                   overrun_set_s;

    // Two-flop synchronizer on every raw sensor line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= {NUM_SENSORS{1'b0}};
            s2_r <= {NUM_SENSORS{1'b0}};
        end else begin
            s1_r <= sensor_raw;
            s2_r <= s1_r;
        end
    end

    // Debounce: a differing level must persist DEBOUNCE_CYCLES edges before it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= {NUM_SENSORS{1'b0}};
            for (int i = 0; i < NUM_SENSORS; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (s2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= CNT_ZERO;
                end else if (cnt_r[i] == CNT_MAX) begin
                    stable_r[i] <= s2_r[i];
                    cnt_r[i]    <= CNT_ZERO;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Rising acceptances coincide with the edge that sets stable.
    always_comb begin
        rise_s = {NUM_SENSORS{1'b0}};
        for (int i = 0; i < NUM_SENSORS; i++) begin
            rise_s[i] = s2_r[i] && (s2_r[i] != stable_r[i]) && (cnt_r[i] == CNT_MAX);
        end
    end

    // Presented event: lowest pending index wins; scan downward so the last hit is the lowest.
    always_comb begin
        y_s  = |pending_r;
        id_s = {ID_W{1'b0}};
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            id_s = pending_r[i] ? ID_W'(i) : id_s;
        end
    end

    // Decode which channel (if any) the controller is acknowledging this cycle.
    always_comb begin
        ack_hit_s = {NUM_SENSORS{1'b0}};
        for (int i = 0; i < NUM_SENSORS; i++) begin
            ack_hit_s[i] = ack && y_s && (id_s == ID_W'(i));
        end
        overrun_set_s = |(rise_s & pending_r & ~ack_hit_s);
    end

    // Pending events: a new rise beats a same-cycle ack so it is never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {NUM_SENSORS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (rise_s[i]) begin
                    pending_r[i] <= 1'b1;
                end else if (ack_hit_s[i]) begin
                    pending_r[i] <= 1'b0;
                end else begin
                    pending_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Sticky overrun; a new loss outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (overrun_set_s) begin
            overrun_r <= 1'b1;
        end else if (clear_overrun) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign y            = y_s;
    assign sensor_id    = id_s;
    assign sensor_level = stable_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_train_sensor_conditioner.sv
// Scoreboard bench for train_sensor_conditioner: directed scenarios plus random
// stimulus, checked against a sample-window reference model.
module tb_train_sensor_conditioner;

    localparam int N   = 4;
    localparam int D   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   sensor_raw;
    logic           ack;
    logic           clear_overrun;
    logic           y;
    logic [IDW-1:0] sensor_id;
    logic [N-1:0]   sensor_level;
    logic           overrun;

    always #5 clk = ~clk;

    train_sensor_conditioner #(
        .NUM_SENSORS    (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensor_raw   (sensor_raw),
        .ack          (ack),
        .clear_overrun(clear_overrun),
        .y            (y),
        .sensor_id    (sensor_id),
        .sensor_level (sensor_level),
        .overrun      (overrun)
    );

    typedef struct packed {
        logic           y;
        logic [IDW-1:0] id;
        logic [N-1:0]   lvl;
        logic           ovr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: raw samples per channel (newest at bit 0), accepted levels, events.
    logic [D+1:0] hist [N];
    logic [N-1:0] m_stable;
    logic [N-1:0] m_pend;
    logic         m_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] p);
        int r = 0;
        for (int i = N - 1; i >= 0; i--) if (p[i]) r = i;
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < N; c++) hist[c] = '0;
        m_stable = '0;
        m_pend   = '0;
        m_ovr    = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the reference model, using the inputs present at that edge.
    task automatic model_edge();
        logic [N-1:0] rise;
        int           acked;
        bit           win;
        bit           new_ovr;
        exp_t         e;
        acked = (ack && (m_pend != '0)) ? lowest(m_pend) : -1;
        rise  = '0;
        for (int c = 0; c < N; c++) begin
            hist[c] = {hist[c][D:0], sensor_raw[c]};
            // synchronized value at edge k is raw sampled at k-2; need D straight differing samples
            win = 1'b1;
            for (int k = 2; k < D + 2; k++) if (hist[c][k] == m_stable[c]) win = 1'b0;
            if (win) begin
                m_stable[c] = ~m_stable[c];
                rise[c]     = m_stable[c];
            end
        end
        new_ovr = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (rise[c]) begin
                if (m_pend[c] && acked != c) new_ovr = 1'b1;
                m_pend[c] = 1'b1;
            end else if (acked == c) begin
                m_pend[c] = 1'b0;
            end
        end
        if (new_ovr) m_ovr = 1'b1;
        else if (clear_overrun) m_ovr = 1'b0;
        e.y   = (m_pend != '0);
        e.id  = IDW'(lowest(m_pend));
        e.lvl = m_stable;
        e.ovr = m_ovr;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs on the falling edge against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("y",            32'(y),            32'(e.y));
            chk("sensor_id",    32'(sensor_id),    32'(e.id));
            chk("sensor_level", 32'(sensor_level), 32'(e.lvl));
            chk("overrun",      32'(overrun),      32'(e.ovr));
        end
    end

    task automatic step(input logic [N-1:0] raw, input logic a, input logic c);
        @(negedge clk);
        sensor_raw    = raw;
        ack           = a;
        clear_overrun = c;
        @(posedge clk);
        model_edge();
    endtask

    task automatic hold(input int n, input logic [N-1:0] raw);
        for (int i = 0; i < n; i++) step(raw, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_y"},   32'(y),            32'd0);
        chk({tag, "_id"},  32'(sensor_id),    32'd0);
        chk({tag, "_lvl"}, 32'(sensor_level), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun),      32'd0);
    endtask

    // Asynchronous reset between edges; inputs keep their values across it.
    task automatic reset_pulse();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero("rst_async");
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        logic [N-1:0] raw;
        rst_n         = 1'b0;
        sensor_raw    = '0;
        ack           = 1'b0;
        clear_overrun = 1'b0;
        #1 check_zero("rst_init");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();

        // Channel 0 qualifies, then acked
        hold(7, 4'b0001);
        step(4'b0001, 1'b1, 1'b0);
        hold(4, 4'b0001);
        hold(10, 4'b0000);

        // Channel 2: 3-cycle glitch rejected, 4-cycle pulse accepted, fall gives no event
        hold(3, 4'b0100);
        hold(10, 4'b0000);
        hold(4, 4'b0100);
        hold(10, 4'b0000);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // Channels 1 and 3 together, drained by two acks
        hold(8, 4'b1010);
        step(4'b1010, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 1'b0);
        hold(3, 4'b1010);
        hold(10, 4'b0000);

        // Overrun on channel 0, then clear
        hold(8, 4'b0001);
        hold(8, 4'b0000);
        hold(8, 4'b0001);
        step(4'b0001, 1'b0, 1'b1);
        hold(2, 4'b0001);
        // Second rise lands exactly on an ack of channel 0
        hold(8, 4'b0000);
        hold(5, 4'b0001);
        step(4'b0001, 1'b1, 1'b0);
        hold(3, 4'b0001);
        step(4'b0001, 1'b1, 1'b0);
        hold(10, 4'b0000);

        // Reset mid-debounce, then re-qualification with the line still high
        hold(2, 4'b0010);
        reset_pulse();
        hold(8, 4'b0010);
        // Reset with an event pending
        reset_pulse();
        hold(8, 4'b0010);
        step(4'b0010, 1'b1, 1'b0);
        hold(10, 4'b0000);

        // Random traffic
        raw = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 7) == 0) raw[c] = ~raw[c];
            end
            if ($urandom_range(0, 599) == 0) begin
                sensor_raw = raw;
                reset_pulse();
            end else begin
                step(raw, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            end
        end

        step('0, 1'b0, 1'b0);
        @(negedge clk);
        #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
